// File: rtl/cp0_pkg.sv
// cp0_pkg: constants shared by the coprocessor-0 block and its users.
//   - register indices for SR/Cause/EPC/PRId
//   - exception codes carried down the pipeline
//   - handler entry PC and the PRId constant
//   - bit positions of the SR and Cause fields
package cp0_pkg;

  localparam logic [4:0]  REG_SR    = 5'd12;
  localparam logic [4:0]  REG_CAUSE = 5'd13;
  localparam logic [4:0]  REG_EPC   = 5'd14;
  localparam logic [4:0]  REG_PRID  = 5'd15;

  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;
  localparam logic [4:0]  EXC_ADES    = 5'd5;
  localparam logic [4:0]  EXC_SYSCALL = 5'd8;
  localparam logic [4:0]  EXC_RI      = 5'd10;
  localparam logic [4:0]  EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE = 32'h4C5A_5150;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  // Return address recorded for a trapped instruction: a delay-slot
  // instruction restarts at its branch. Plain 32-bit wrap, no alignment.
  function automatic logic [31:0] epc_of(input logic [31:0] vpc, input logic bd);
    return bd ? (vpc - 32'd4) : vpc;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: M-stage side of coprocessor 0.
//   master: pipeline (drives mtc0/eret/exception info, receives Req/EPC/read data)
//   slave : cp0
// There is no valid/ready handshake here: every input is a level that is
// meaningful for the current cycle only, and every output is combinational
// and valid within that same cycle. en and EXLClr are single-cycle
// qualifiers; ExcCodeIn = 0 means "no exception".
interface cp0_if;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor 0 for the five-stage MIPS pipeline, beside the M stage.
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - cp0_if.slave: mtc0/mfc0 access, exception/interrupt inputs,
//          Req (flush-and-redirect), EPCOut (eret target)
// Holds SR (IM/EXL/IE), Cause (BD/IP/ExcCode), EPC and the constant PRId.
module cp0
  import cp0_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        wr_sr;
  logic        wr_epc;

  // EXL masks everything, so there is never a nested trap.
  assign int_req = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (bus.ExcCodeIn != EXC_INT) & ~sr_exl;
  assign req     = int_req | exc_req;

  // mtc0 is dropped when the instruction carrying it is being cancelled.
  assign wr_sr  = bus.en & ~req & (bus.CP0Add == REG_SR);
  assign wr_epc = bus.en & ~req & (bus.CP0Add == REG_EPC);

  always_comb begin
    sr_word = '0;
    sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
    sr_word[SR_EXL_BIT]        = sr_exl;
    sr_word[SR_IE_BIT]         = sr_ie;
  end

  always_comb begin
    cause_word = '0;
    cause_word[CAUSE_BD_BIT]              = cause_bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  // Read mux shows pre-edge state; mfc0 after mtc0 must be stalled upstream.
  always_comb begin
    bus.CP0Out = '0;
    case (bus.CP0Add)
      REG_SR:    bus.CP0Out = sr_word;
      REG_CAUSE: bus.CP0Out = cause_word;
      REG_EPC:   bus.CP0Out = epc;
      REG_PRID:  bus.CP0Out = PRID_VALUE;
      default:   bus.CP0Out = '0;
    endcase
  end

  assign bus.Req    = req;
  assign bus.EPCOut = epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      // Pending-interrupt view follows the lines every cycle, even under EXL.
      cause_ip <= bus.HWInt;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.BDIn;
        cause_exc <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc       <= epc_of(bus.VPC, bus.BDIn);
      end else begin
        if (wr_sr) begin
          sr_im  <= bus.CP0In[SR_IM_HI:SR_IM_LO];
          sr_ie  <= bus.CP0In[SR_IE_BIT];
          sr_exl <= bus.CP0In[SR_EXL_BIT];
        end
        if (wr_epc) begin
          epc <= bus.CP0In;
        end
        // eret overrides a same-cycle mtc0 on the EXL bit only.
        if (bus.EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;

  logic clk;
  logic rst;
  cp0_if bus();

  cp0 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference state as whole architectural register words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic m_int();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h4C5A_5150;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.en = 1'b0; bus.CP0Add = 5'd0; bus.CP0In = 32'h0; bus.VPC = 32'h0;
    bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic clk_edge();
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (m_req()) begin
        m_cause = (bus.BDIn ? 32'h8000_0000 : 32'h0) |
                  (m_int() ? 32'h0 : 32'(bus.ExcCodeIn) * 4);
        m_epc   = bus.VPC - (bus.BDIn ? 32'd4 : 32'd0);
        m_sr    = m_sr | 32'h2;
      end else begin
        if (bus.en && bus.CP0Add == 5'd12) m_sr = bus.CP0In & 32'h0000_FC03;
        if (bus.en && bus.CP0Add == 5'd14) m_epc = bus.CP0In;
        if (bus.EXLClr) m_sr = m_sr & ~32'h2;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(bus.HWInt) << 10);
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.CP0Add = a; bus.CP0In = d;
    clk_edge();
  endtask

  task automatic eret();
    bus.EXLClr = 1'b1;
    clk_edge();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp_v [4] = '{32'h0, 32'h0, 32'h0, 32'h4C5A_5150};
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.CP0Add = 5'(12 + i); #1;
      checks++;
      if (bus.CP0Out !== exp_v[i]) begin
        errors++; $display("FAIL reset_read idx=%0d got=%h exp=%h", 12 + i, bus.CP0Out, exp_v[i]);
      end
    end
    bus.CP0Add = 5'd3; #1;
    checks++;
    if (bus.CP0Out !== 32'h0) begin errors++; $display("FAIL reset_read_other got=%h exp=0", bus.CP0Out); end
    checks++;
    if (bus.Req !== 1'b0 || bus.EPCOut !== 32'h0) begin
      errors++; $display("FAIL reset_outputs req=%b epc=%h exp req=0 epc=0", bus.Req, bus.EPCOut);
    end
  endtask

  task automatic test_overflow();
    bus.ExcCodeIn = 5'd12; bus.VPC = 32'h3010; bus.BDIn = 1'b0; #1;
    checks++;
    if (bus.Req !== 1'b1) begin errors++; $display("FAIL ov_req got=%b exp=1", bus.Req); end
    clk_edge();
    bus.ExcCodeIn = 5'd12; #1;
    checks++;
    if (bus.Req !== 1'b0) begin errors++; $display("FAIL ov_masked_by_exl got=%b exp=0", bus.Req); end
    bus.ExcCodeIn = 5'd0;
    bus.CP0Add = 5'd14; #1;
    checks++;
    if (bus.CP0Out !== 32'h3010) begin errors++; $display("FAIL ov_epc got=%h exp=00003010", bus.CP0Out); end
    bus.CP0Add = 5'd13; #1;
    checks++;
    if (bus.CP0Out !== 32'h30) begin errors++; $display("FAIL ov_cause got=%h exp=00000030", bus.CP0Out); end
    bus.CP0Add = 5'd12; #1;
    checks++;
    if (bus.CP0Out !== 32'h2) begin errors++; $display("FAIL ov_sr got=%h exp=00000002", bus.CP0Out); end
    eret();
  endtask

  task automatic test_delay_slot();
    bus.ExcCodeIn = 5'd4; bus.VPC = 32'h3020; bus.BDIn = 1'b1;
    clk_edge();
    checks++;
    if (bus.EPCOut !== 32'h301C) begin errors++; $display("FAIL bd_epc got=%h exp=0000301c", bus.EPCOut); end
    bus.CP0Add = 5'd13; #1;
    checks++;
    if (bus.CP0Out !== 32'h8000_0010) begin errors++; $display("FAIL bd_cause got=%h exp=80000010", bus.CP0Out); end
    eret();
  endtask

  task automatic test_int_priority();
    mtc0(5'd12, 32'h0000_0401);
    bus.CP0Add = 5'd12; #1;
    checks++;
    if (bus.CP0Out !== 32'h401) begin errors++; $display("FAIL int_sr_setup got=%h exp=00000401", bus.CP0Out); end
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd10; bus.VPC = 32'h3040; #1;
    checks++;
    if (bus.Req !== 1'b1) begin errors++; $display("FAIL int_req got=%b exp=1", bus.Req); end
    clk_edge();
    bus.CP0Add = 5'd13; #1;
    checks++;
    if (bus.CP0Out !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got=%h exp=00000400", bus.CP0Out); end
  endtask

  task automatic test_eret_mtc0();
    // EXL is still set from the interrupt above.
    bus.HWInt = 6'b000001; bus.EXLClr = 1'b1;
    bus.en = 1'b1; bus.CP0Add = 5'd12; bus.CP0In = 32'h0000_FC03; #1;
    checks++;
    if (bus.Req !== 1'b0) begin errors++; $display("FAIL eret_masked got=%b exp=0", bus.Req); end
    clk_edge();
    bus.CP0Add = 5'd12; #1;
    checks++;
    if (bus.CP0Out !== 32'h0000_FC01) begin errors++; $display("FAIL eret_sr got=%h exp=0000fc01", bus.CP0Out); end
    bus.HWInt = 6'b100000; #1;
    checks++;
    if (bus.Req !== 1'b1) begin errors++; $display("FAIL eret_then_int got=%b exp=1", bus.Req); end
    clk_edge();
    eret();
  endtask

  task automatic test_mtc0_suppressed();
    bus.en = 1'b1; bus.CP0Add = 5'd14; bus.CP0In = 32'hDEAD_BEEF;
    bus.ExcCodeIn = 5'd8; bus.VPC = 32'h3000; #1;
    checks++;
    if (bus.Req !== 1'b1) begin errors++; $display("FAIL supp_req got=%b exp=1", bus.Req); end
    clk_edge();
    checks++;
    if (bus.EPCOut !== 32'h3000) begin errors++; $display("FAIL supp_epc got=%h exp=00003000", bus.EPCOut); end
    bus.CP0Add = 5'd13; #1;
    checks++;
    if (bus.CP0Out !== 32'h20) begin errors++; $display("FAIL supp_cause got=%h exp=00000020", bus.CP0Out); end
    eret();
  endtask

  task automatic test_epc_wrap();
    bus.ExcCodeIn = 5'd5; bus.VPC = 32'h0; bus.BDIn = 1'b1;
    clk_edge();
    checks++;
    if (bus.EPCOut !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap got=%h exp=fffffffc", bus.EPCOut); end
    eret();
    mtc0(5'd14, 32'h1234_5679);
    checks++;
    if (bus.EPCOut !== 32'h1234_5679) begin errors++; $display("FAIL mtc0_epc got=%h exp=12345679", bus.EPCOut); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    bus.CP0Add = 5'd13; #1;
    checks++;
    if (bus.CP0Out !== m_read(5'd13)) begin errors++; $display("FAIL cause_readonly got=%h exp=%h", bus.CP0Out, m_read(5'd13)); end
    mtc0(5'd15, 32'h0);
    bus.CP0Add = 5'd15; #1;
    checks++;
    if (bus.CP0Out !== 32'h4C5A_5150) begin errors++; $display("FAIL prid_readonly got=%h exp=4c5a5150", bus.CP0Out); end
  endtask

  task automatic test_rst_with_req();
    bus.ExcCodeIn = 5'd12; bus.VPC = 32'h3050; #1;
    checks++;
    if (bus.Req !== 1'b1) begin errors++; $display("FAIL rstreq_req got=%b exp=1", bus.Req); end
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    for (int i = 12; i < 15; i++) begin
      bus.CP0Add = 5'(i); #1;
      checks++;
      if (bus.CP0Out !== 32'h0) begin errors++; $display("FAIL rstreq_clear idx=%0d got=%h exp=0", i, bus.CP0Out); end
    end
  endtask

  task automatic test_random();
    logic [4:0] codes [6] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    for (int n = 0; n < 400; n++) begin
      bus.en        = ($urandom_range(0, 2) == 0);
      bus.CP0Add    = 5'($urandom_range(10, 17));
      bus.CP0In     = $urandom;
      bus.VPC       = $urandom;
      bus.BDIn      = 1'($urandom_range(0, 1));
      bus.ExcCodeIn = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(1, 5)] : 5'd0;
      bus.HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.EXLClr    = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (bus.Req !== m_req()) begin errors++; $display("FAIL rand_req n=%0d got=%b exp=%b", n, bus.Req, m_req()); end
      checks++;
      if (bus.EPCOut !== m_epc) begin errors++; $display("FAIL rand_epc n=%0d got=%h exp=%h", n, bus.EPCOut, m_epc); end
      checks++;
      if (bus.CP0Out !== m_read(bus.CP0Add)) begin
        errors++; $display("FAIL rand_read n=%0d idx=%0d got=%h exp=%h", n, bus.CP0Add, bus.CP0Out, m_read(bus.CP0Add));
      end
      clk_edge();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    set_idle();
    @(posedge clk); #1;
    test_reset();
    test_overflow();
    test_delay_slot();
    test_int_priority();
    test_eret_mtc0();
    test_mtc0_suppressed();
    test_epc_wrap();
    test_rst_with_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the exception-capable five-stage MIPS pipeline. Sits beside the M stage. It consumes the exception code, branch-delay flag and PC that the pipeline registers carry down from F/D/E, plus the six hardware interrupt lines. It then raises Req, the flush-and-redirect request that every pipeline register obeys by loading handler PC 0x0000_4180. It also holds SR, Cause and EPC, and services mtc0, mfc0 and eret.

## Interface
- No parameters. All constants live in the shared package.
- clk  in  1  sole clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  mtc0 write enable from the M-stage instruction.
- CP0Add  in  5  register index for mtc0 and mfc0.
- CP0In  in  32  mtc0 write data (M-stage rt value).
- CP0Out  out  32  mfc0 read data, combinational from CP0Add.
- VPC  in  32  PC of the instruction currently in M.
- BDIn  in  1  M instruction sits in a branch delay slot.
- ExcCodeIn  in  5  exception code carried to M; 0 = none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret is in M.
- EPCOut  out  32  current EPC, combinational, feeds eret redirect.
- Req  out  1  take exception or interrupt now. Combinational; drives flush of every pipeline register.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant 0x4C5A_5150, read-only.
  - Any other index reads 0 and ignores writes.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq.
- Priority: the interrupt wins over a simultaneous exception.
- On a clock edge with Req = 1:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC - 4 : VPC.
  - mtc0 in the same cycle is suppressed, because the instruction is being cancelled.
- Cause.IP <= HWInt on every edge, regardless of Req, en or EXL.
- When Req = 0 and en = 1, mtc0 writes only the writable fields:
  - SR: IM, EXL and IE.
  - EPC: full word.
  - Cause: no writable fields.
- When Req = 0 and EXLClr = 1: SR.EXL <= 0.
  - If mtc0 to SR also occurs in the same cycle, EXLClr wins on the EXL bit only.
- EPC arithmetic is a 32-bit wrap: VPC = 0 with BD gives 0xFFFF_FFFC. No alignment is forced.
- CP0Out is not forwarded. It reflects state before the current edge's write. Hazard logic must stall mfc0 behind mtc0.

## Timing
- Reset: SR, Cause and EPC all become 0. Consequently Req = 0, EPCOut = 0 and CP0Out = 0 for every index except PRId.
- Req is valid in the same cycle its inputs are valid; latency 0.
- Next edge, Req = 1 causes:
  - CP0 state captures the event.
  - Pipeline registers load PC 0x4180 with zeroed IR, EXC and BD.
  - Hence Req is low in the following cycle, since EXL = 1.
- While EXL = 1, further ExcCodeIn and interrupts are masked (no nesting). Cause.IP still tracks HWInt.
- EPCOut reflects an mtc0 to EPC starting the cycle after the write edge. eret in M during that cycle sees the new value.
- rst asserted together with Req: rst wins and all state clears. Req is still high combinationally in that cycle, which is harmless because every pipeline register also resets.
- Cycle after eret (EXL cleared): a pending enabled interrupt raises Req immediately.

## Structure
- Shared package holds:
  - register indices 12/13/14/15;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
  - handler entry 0x0000_4180;
  - PRId value;
  - SR/Cause bit positions.
- Single flat module, no sub-module. Req and read mux are combinational; one clocked always block holds all state.

## Test plan
- Reset, then read indices 12/13/14/15 → CP0Out = 0, 0, 0, 0x4C5A_5150; Req = 0.
- Overflow exception, not in a delay slot:
  - Stimulus: ExcCodeIn = 12, VPC = 0x3010, BDIn = 0.
  - Same cycle: Req = 1.
  - Next cycle: EPC = 0x3010, Cause = 0x0000_0030, SR.EXL = 1, Req = 0.
- Exception in a delay slot:
  - Stimulus: ExcCodeIn = 4, VPC = 0x3020, BDIn = 1.
  - Response: EPC = 0x301C, Cause.BD = 1, ExcCode = 4.
- Interrupt beats exception:
  - Setup: mtc0 SR = 0x0000_0401.
  - Stimulus: HWInt = 6'b000001 with ExcCodeIn = 10.
  - Response: Req = 1, Cause.ExcCode = 0, IP = 0x01.
- eret and mtc0 in the same cycle:
  - Setup: EXL = 1.
  - Stimulus: EXLClr = 1 with mtc0 SR = 0x0000_FC03.
  - Response: SR = 0x0000_FC01 next cycle; Req = 1 the cycle after that if HWInt is nonzero.
- mtc0 suppressed by Req:
  - Stimulus: en = 1, CP0Add = 14, CP0In = 0xDEAD_BEEF, with ExcCodeIn = 8 and VPC = 0x3000.
  - Response: EPC = 0x3000, not the written value.
